rom_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous ROM between NPORTS independent read requesters (e.g. CPU fetch, tile fetch, sprite fetch).
- Accepts one new read per clock, fully pipelined across the ROM's fixed read latency.
- Tags each read with its port ID and returns the data to the right port with a one-cycle valid pulse.
- Sits between the requesters and the ROM instance, and is the only driver of the ROM's enable and address.

---
 rtl/rom_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_rom_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous ROM between NPORTS
// requesters. One read is issued per clock. Each read carries a port tag
// through a pipeline matched to the ROM latency, so its data returns to the
// port that asked for it.
module rom_rr_arbiter #(
  parameter int unsigned NPORTS      = 4,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORTS-1:0]            REQ,
  input  logic [NPORTS*ADDR_WIDTH-1:0] ADDR,
  output logic [NPORTS*DATA_WIDTH-1:0] DOUT,
  output logic [NPORTS-1:0]            DV,
  output logic [NPORTS-1:0]            GNT,
  output logic                         ROM_CEN,
  output logic [ADDR_WIDTH-1:0]        ROM_ADDR,
  input  logic [DATA_WIDTH-1:0]        ROM_DATA
);

  localparam int unsigned IdW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  typedef logic [IdW-1:0] id_t;

  // Architectural state
  id_t                         ptr_q;
  logic [NPORTS-1:0]           pending_q, pending_d;
  logic [NPORTS-1:0]           gnt_q, gnt_d;
  logic                        cen_q;
  logic [ADDR_WIDTH-1:0]       rom_addr_q, rom_addr_d;
  logic [NPORTS*DATA_WIDTH-1:0] dout_q, dout_d;
  logic [NPORTS-1:0]           dv_q, dv_d;

  // Tag pipeline; stage 0 is loaded on the grant edge, so stage ROM_LATENCY
  // lines up with ROM_DATA for that read.
  logic [ROM_LATENCY:0]        tag_vld_q;
  id_t                         tag_id_q [0:ROM_LATENCY];

  // Arbitration results
  logic [NPORTS-1:0]           eligible;
  logic                        win_vld;
  id_t                         win_id;
  id_t                         cand;
  id_t                         ptr_nxt;
  logic                        ret_vld;
  id_t                         ret_id;

  assign ret_vld = tag_vld_q[ROM_LATENCY];
  assign ret_id  = tag_id_q[ROM_LATENCY];

  // Pick the first eligible port at or above the pointer, wrapping around.
  // A port returning data this cycle is excluded so it can drop REQ first.
  always_comb begin
    eligible = REQ & ~pending_q & ~dv_q;
    win_vld  = 1'b0;
    win_id   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      cand = id_t'((32'(ptr_q) + k) % NPORTS);
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
    ptr_nxt = (win_id == id_t'(NPORTS - 1)) ? '0 : win_id + 1'b1;
  end

  // Next state for issue and return; a port cannot be granted and returned
  // in the same cycle because a granted port stays pending until its return.
  always_comb begin
    pending_d  = pending_q;
    dout_d     = dout_q;
    dv_d       = '0;
    gnt_d      = '0;
    rom_addr_d = rom_addr_q;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (ret_vld && ret_id == id_t'(i)) begin
        pending_d[i]                         = 1'b0;
        dv_d[i]                              = 1'b1;
        dout_d[i*DATA_WIDTH +: DATA_WIDTH]   = ROM_DATA;
      end
      if (win_vld && win_id == id_t'(i)) begin
        pending_d[i] = 1'b1;
        gnt_d[i]     = 1'b1;
        rom_addr_d   = ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Register all state; reset discards in-flight reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      pending_q  <= '0;
      gnt_q      <= '0;
      cen_q      <= 1'b0;
      rom_addr_q <= '0;
      dout_q     <= '0;
      dv_q       <= '0;
      tag_vld_q  <= '0;
      for (int unsigned s = 0; s <= ROM_LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      if (win_vld) begin
        ptr_q <= ptr_nxt;
      end
      pending_q   <= pending_d;
      gnt_q       <= gnt_d;
      cen_q       <= win_vld;
      rom_addr_q  <= rom_addr_d;
      dout_q      <= dout_d;
      dv_q        <= dv_d;
      tag_vld_q   <= {tag_vld_q[ROM_LATENCY-1:0], win_vld};
      tag_id_q[0] <= win_id;
      for (int unsigned s = 1; s <= ROM_LATENCY; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  assign DOUT     = dout_q;
  assign DV       = dv_q;
  assign GNT      = gnt_q;
  assign ROM_CEN  = cen_q;
  assign ROM_ADDR = rom_addr_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed bench for rom_rr_arbiter: one instance at ROM_LATENCY=1 and one
// at ROM_LATENCY=2, each with its own behavioural ROM.
module tb_rom_rr_arbiter;

  localparam int NP = 4;
  localparam int AW = 15;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NP-1:0]    req1, dv1, gnt1, req2, dv2, gnt2;
  logic [NP*AW-1:0] addr1, addr2;
  logic [NP*DW-1:0] dout1, dout2;
  logic             cen1, cen2;
  logic [AW-1:0]    raddr1, raddr2;
  logic [DW-1:0]    rdata1, rdata2, r2a;

  int comps = 0;
  int fails = 0;

  rom_rr_arbiter #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .REQ(req1), .ADDR(addr1), .DOUT(dout1), .DV(dv1),
    .GNT(gnt1), .ROM_CEN(cen1), .ROM_ADDR(raddr1), .ROM_DATA(rdata1)
  );

  rom_rr_arbiter #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .REQ(req2), .ADDR(addr2), .DOUT(dout2), .DV(dv2),
    .GNT(gnt2), .ROM_CEN(cen2), .ROM_ADDR(raddr2), .ROM_DATA(rdata2)
  );

  // ROM contents: 0xA5 at 0x1234, otherwise low address byte xor 0x3C
  function automatic logic [7:0] rom_f(input logic [14:0] a);
    if (a == 15'h1234) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    if (cen1) rdata1 <= rom_f(raddr1);
  end

  always @(posedge clk) begin
    if (cen2) r2a <= rom_f(raddr2);
    rdata2 <= r2a;
  end

  // Advance to the next cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req1 = '0; req2 = '0; addr1 = '0; addr2 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    comps++; if (dout1 !== '0) begin fails++; $display("FAIL reset_dout1: got %h want 0", dout1); end
    comps++; if (dv1 !== '0) begin fails++; $display("FAIL reset_dv1: got %b want 0", dv1); end
    comps++; if (gnt1 !== '0) begin fails++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    comps++; if (cen1 !== 1'b0) begin fails++; $display("FAIL reset_cen1: got %b want 0", cen1); end
    comps++; if (raddr1 !== '0) begin fails++; $display("FAIL reset_raddr1: got %h want 0", raddr1); end
    comps++; if ({dout2, dv2, gnt2, cen2, raddr2} !== '0) begin
      fails++; $display("FAIL reset_dut2: got %h want 0", {dout2, dv2, gnt2, cen2, raddr2});
    end
  endtask

  task automatic test_single();
    do_reset();
    req1 = 4'b0001;
    addr1[0 +: AW] = 15'h1234;
    tick(); // cycle 1
    comps++; if (gnt1 !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b want 0001", gnt1); end
    comps++; if (raddr1 !== 15'h1234) begin fails++; $display("FAIL single_raddr: got %h want 1234", raddr1); end
    comps++; if (cen1 !== 1'b1) begin fails++; $display("FAIL single_cen: got %b want 1", cen1); end
    tick(); // cycle 2
    comps++; if (dv1 !== 4'b0000) begin fails++; $display("FAIL single_dv_c2: got %b want 0000", dv1); end
    tick(); // cycle 3
    comps++; if (dv1 !== 4'b0001) begin fails++; $display("FAIL single_dv_c3: got %b want 0001", dv1); end
    comps++; if (dout1[7:0] !== 8'hA5) begin fails++; $display("FAIL single_dout: got %h want a5", dout1[7:0]); end
    req1 = '0;
    tick(); // cycle 4
    comps++; if (dv1 !== 4'b0000) begin fails++; $display("FAIL single_dv_c4: got %b want 0000", dv1); end
    comps++; if ({gnt1, cen1} !== 5'b0) begin fails++; $display("FAIL single_idle_c4: got %b want 0", {gnt1, cen1}); end
  endtask

  task automatic test_contention();
    logic [3:0] eg, ed;
    logic [7:0] data_exp [4] = '{8'h3C, 8'h3D, 8'h3E, 8'h3F};
    do_reset();
    for (int p = 0; p < NP; p++) addr1[p*AW +: AW] = AW'(p);
    req1 = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      tick();
      eg = 4'b0001 << ((c - 1) % 4);
      ed = (c >= 3) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000;
      comps++; if (gnt1 !== eg) begin fails++; $display("FAIL contention_gnt c%0d: got %b want %b", c, gnt1, eg); end
      comps++; if (raddr1 !== AW'((c - 1) % 4)) begin
        fails++; $display("FAIL contention_raddr c%0d: got %h want %h", c, raddr1, (c - 1) % 4);
      end
      comps++; if (dv1 !== ed) begin fails++; $display("FAIL contention_dv c%0d: got %b want %b", c, dv1, ed); end
      if (c >= 3) begin
        comps++; if (dout1[((c - 3) % 4)*DW +: DW] !== data_exp[(c - 3) % 4]) begin
          fails++; $display("FAIL contention_dout c%0d: got %h want %h", c,
                            dout1[((c - 3) % 4)*DW +: DW], data_exp[(c - 3) % 4]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] eg, ed;
    do_reset();
    addr1[0 +: AW] = 15'h0010;
    addr1[AW +: AW] = 15'h0020;
    req1 = 4'b0011;
    for (int c = 1; c <= 5; c++) begin
      tick();
      eg = (c == 1) ? 4'b0001 : (c == 2) ? 4'b0010 : 4'b0000;
      ed = (c == 3) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000;
      comps++; if (gnt1 !== eg) begin fails++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, gnt1, eg); end
      comps++; if (cen1 !== (c <= 2)) begin fails++; $display("FAIL b2b_cen c%0d: got %b want %b", c, cen1, c <= 2); end
      comps++; if (dv1 !== ed) begin fails++; $display("FAIL b2b_dv c%0d: got %b want %b", c, dv1, ed); end
      if (c == 3) begin
        comps++; if (dout1[7:0] !== 8'h2C) begin fails++; $display("FAIL b2b_dout0: got %h want 2c", dout1[7:0]); end
        req1[0] = 1'b0;
      end
      if (c == 4) begin
        comps++; if (dout1[15:8] !== 8'h1C) begin fails++; $display("FAIL b2b_dout1: got %h want 1c", dout1[15:8]); end
        req1[1] = 1'b0;
      end
    end
  endtask

  task automatic test_rerequest();
    logic [3:0] eg, ed;
    do_reset();
    addr1[2*AW +: AW] = 15'h0055;
    req1 = 4'b0100;
    for (int c = 1; c <= 9; c++) begin
      tick();
      eg = (c == 1 || c == 5) ? 4'b0100 : 4'b0000;
      ed = (c == 3 || c == 7) ? 4'b0100 : 4'b0000;
      comps++; if (gnt1 !== eg) begin fails++; $display("FAIL rereq_gnt c%0d: got %b want %b", c, gnt1, eg); end
      comps++; if (dv1 !== ed) begin fails++; $display("FAIL rereq_dv c%0d: got %b want %b", c, dv1, ed); end
      if (c == 3 || c == 7) begin
        comps++; if (dout1[23:16] !== 8'h69) begin fails++; $display("FAIL rereq_dout c%0d: got %h want 69", c, dout1[23:16]); end
      end
      if (c == 8) req1 = '0;
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    addr1[AW +: AW] = 15'h0077;
    req1 = 4'b0010;
    tick(); // cycle 1
    comps++; if (gnt1 !== 4'b0010) begin fails++; $display("FAIL mid_gnt: got %b want 0010", gnt1); end
    reset = 1'b1;
    req1 = '0;
    tick(); // cycle 2
    reset = 1'b0;
    comps++; if ({dout1, dv1, gnt1, cen1, raddr1} !== '0) begin
      fails++; $display("FAIL mid_outputs: got %h want 0", {dout1, dv1, gnt1, cen1, raddr1});
    end
    for (int c = 3; c <= 6; c++) begin
      tick();
      comps++; if (dv1 !== 4'b0000) begin fails++; $display("FAIL mid_dv c%0d: got %b want 0000", c, dv1); end
    end
    addr1[3*AW +: AW] = 15'h0078;
    req1 = 4'b1010;
    tick(); // cycle 7
    comps++; if (gnt1 !== 4'b0010) begin fails++; $display("FAIL mid_ptr_gnt: got %b want 0010", gnt1); end
    comps++; if (raddr1 !== 15'h0077) begin fails++; $display("FAIL mid_ptr_raddr: got %h want 0077", raddr1); end
    req1 = '0;
  endtask

  task automatic test_latency2();
    logic [3:0] eg, ed;
    logic [7:0] ex;
    do_reset();
    addr2[3*AW +: AW] = 15'h0142;
    req2 = 4'b1000;
    for (int c = 1; c <= 11; c++) begin
      tick();
      eg = (c == 1 || c == 8) ? 4'b1000 : 4'b0000;
      ed = (c == 4 || c == 11) ? 4'b1000 : 4'b0000;
      ex = (c < 4) ? 8'h00 : (c < 11) ? 8'h7E : 8'h7F;
      comps++; if (gnt2 !== eg) begin fails++; $display("FAIL lat2_gnt c%0d: got %b want %b", c, gnt2, eg); end
      comps++; if (dv2 !== ed) begin fails++; $display("FAIL lat2_dv c%0d: got %b want %b", c, dv2, ed); end
      comps++; if (dout2[31:24] !== ex) begin fails++; $display("FAIL lat2_dout3 c%0d: got %h want %h", c, dout2[31:24], ex); end
      if (c == 4) req2 = '0;
      if (c == 7) begin
        addr2[3*AW +: AW] = 15'h0143;
        req2 = 4'b1000;
      end
      if (c == 11) req2 = '0;
    end
    comps++; if (dout2[23:0] !== 24'h0) begin fails++; $display("FAIL lat2_other_dout: got %h want 0", dout2[23:0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_rerequest();
    test_reset_midflight();
    test_latency2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
